// File: rtl/or_gate_pkg.sv
// ----------------------------------------------------------------------------
// or_gate_pkg
//   Shared constants and a configuration helper for the or_gate_unit block.
//   The per-stage struct (valid + data) depends on WIDTH, so it is declared
//   inside or_gate_unit where WIDTH is known.
// ----------------------------------------------------------------------------
package or_gate_pkg;

    localparam int DEFAULT_WIDTH   = 1;
    localparam int MAX_PIPE_STAGES = 4;

    // True when a requested register depth is inside the supported range.
    function automatic bit pipe_stages_legal(input int n);
        return (n >= 1) && (n <= MAX_PIPE_STAGES);
    endfunction

endpackage

// File: rtl/or_pipe_stage.sv
// ----------------------------------------------------------------------------
// or_pipe_stage
//   One register stage of the registered OR path: a valid bit and a data word.
//   Data is captured every cycle whatever the valid bit says; only the valid
//   bit tells consumers whether the data means anything.
//
// Ports
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low clear of valid and data
//   i_valid  : valid from the previous stage (or from the block input)
//   i_data   : data from the previous stage (or in1 | in2)
//   o_valid  : registered valid
//   o_data   : registered data
// ----------------------------------------------------------------------------
module or_pipe_stage #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= i_valid;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/or_gate_unit.sv
// ----------------------------------------------------------------------------
// or_gate_unit
//   Two-operand bitwise OR primitive.  out1 is the plain combinational OR.
//   A parallel registered copy (PIPE_STAGES deep, valid-qualified) and a
//   reduction-OR flag of that copy serve clocked consumers.  No back-pressure:
//   a new operand pair is accepted every cycle.
//
// Handshake: in_valid marks in1/in2 as meaningful for the registered path;
//   out_valid marks out1_q (and any_q) as meaningful exactly PIPE_STAGES
//   cycles later.  There is no ready; data regs load every cycle and
//   out1_q must be ignored while out_valid is 0.
//
// Parameters
//   WIDTH        : operand/result width (>= 1)
//   PIPE_STAGES  : register stages on the registered path (1..4)
//
// Ports
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   in1, in2     : operands
//   in_valid     : qualifies in1/in2 for the registered path
//   out1         : combinational in1 | in2 (unaffected by reset)
//   out1_q       : registered in1 | in2, PIPE_STAGES cycles later
//   out_valid    : qualifies out1_q
//   any_q        : reduction OR of out1_q
//
// Optional feature, macro OR_GATE_STICKY_EN:
//   sticky_clr   : synchronous clear of the accumulator (wins over accumulate)
//   sticky_q     : OR-accumulation of every valid out1_q since last clear
// ----------------------------------------------------------------------------
module or_gate_unit
    import or_gate_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int PIPE_STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             in_valid,
`ifdef OR_GATE_STICKY_EN
    input  logic             sticky_clr,
`endif
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out1_q,
    output logic             out_valid,
    output logic             any_q
`ifdef OR_GATE_STICKY_EN
    ,
    output logic [WIDTH-1:0] sticky_q
`endif
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } or_stage_t;

    if (!pipe_stages_legal(PIPE_STAGES) || (WIDTH < 1)) begin : g_bad_cfg
        $error("or_gate_unit: WIDTH must be >= 1 and PIPE_STAGES within 1..MAX_PIPE_STAGES");
    end

    // w_stage[0] is the input side of the first register; w_stage[k] is the
    // output of register k-1, so w_stage[PIPE_STAGES] is the block output.
    or_stage_t w_stage [PIPE_STAGES+1];

    assign out1             = in1 | in2;
    assign w_stage[0].valid = in_valid;
    assign w_stage[0].data  = in1 | in2;

    for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage
        or_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_valid (w_stage[g].valid),
            .i_data  (w_stage[g].data),
            .o_valid (w_stage[g+1].valid),
            .o_data  (w_stage[g+1].data)
        );
    end

    assign out1_q    = w_stage[PIPE_STAGES].data;
    assign out_valid = w_stage[PIPE_STAGES].valid;
    // Reset clears the data registers, so any_q is 0 in reset without gating.
    assign any_q     = |w_stage[PIPE_STAGES].data;

`ifdef OR_GATE_STICKY_EN
    logic [WIDTH-1:0] r_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= '0;
        end else if (sticky_clr) begin
            r_sticky <= '0;
        end else if (out_valid) begin
            r_sticky <= r_sticky | out1_q;
        end
    end

    assign sticky_q = r_sticky;
`endif

endmodule

// File: tb/tb_or_gate_unit.sv
// ----------------------------------------------------------------------------
// tb_or_gate_unit
//   Directed bench for or_gate_unit: a WIDTH=1 instance for the combinational
//   truth table and a WIDTH=8, PIPE_STAGES=2 instance for the registered path.
//   Inputs change on the falling edge; outputs are sampled on the falling edge
//   (or a few time units after an asynchronous event).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_or_gate_unit;

  localparam int W  = 8;
  localparam int PS = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic         a1, b1, v1;
  logic         o1, o1_q, ov1, any1;
  logic [W-1:0] in1, in2;
  logic         in_valid;
  logic [W-1:0] out1, out1_q;
  logic         out_valid, any_q;
`ifdef OR_GATE_STICKY_EN
  logic         clr1, sticky1;
  logic         sticky_clr;
  logic [W-1:0] sticky_q;
`endif

  or_gate_unit #(.WIDTH(1), .PIPE_STAGES(1)) u_dut_w1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in1        (a1),
    .in2        (b1),
    .in_valid   (v1),
`ifdef OR_GATE_STICKY_EN
    .sticky_clr (clr1),
`endif
    .out1       (o1),
    .out1_q     (o1_q),
    .out_valid  (ov1),
    .any_q      (any1)
`ifdef OR_GATE_STICKY_EN
    ,
    .sticky_q   (sticky1)
`endif
  );

  or_gate_unit #(.WIDTH(W), .PIPE_STAGES(PS)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in1        (in1),
    .in2        (in2),
    .in_valid   (in_valid),
`ifdef OR_GATE_STICKY_EN
    .sticky_clr (sticky_clr),
`endif
    .out1       (out1),
    .out1_q     (out1_q),
    .out_valid  (out_valid),
    .any_q      (any_q)
`ifdef OR_GATE_STICKY_EN
    ,
    .sticky_q   (sticky_q)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic v);
    @(negedge clk);
    in1      = a;
    in2      = b;
    in_valid = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 8'h00, 1'b0);
  endtask

  // ---------------- directed tables ----------------
  logic [W-1:0] tp_a   [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'hF0, 8'h00};
  logic [W-1:0] tp_b   [10] = '{8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F, 8'h00};
  logic [W-1:0] tp_exp [10] = '{8'h11, 8'h22, 8'h44, 8'h88, 8'h11, 8'h22, 8'h44, 8'h88, 8'hFF, 8'h00};

  logic [1:0] tt_in  [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
  logic       tt_exp [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

  // ---------------- stimulus ----------------
  initial begin
    a1 = 1'b0; b1 = 1'b0; v1 = 1'b0;
    in1 = '0; in2 = '0; in_valid = 1'b0;
`ifdef OR_GATE_STICKY_EN
    clr1 = 1'b0; sticky_clr = 1'b0;
`endif

    // Reset state, checked while reset is held.
    #2;
    check("rst_out1_q", 32'(out1_q), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_any_q", 32'(any_q), 32'h0);
    check("rst_w1_valid", 32'(ov1), 32'h0);

    // WIDTH=1 truth table, purely combinational, no clock edge needed.
    for (int i = 0; i < 4; i++) begin
      a1 = tt_in[i][1];
      b1 = tt_in[i][0];
      #7;
      check($sformatf("tt_%0d%0d", tt_in[i][1], tt_in[i][0]), 32'(o1), 32'(tt_exp[i]));
    end

    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Single transaction A0 | 05 with two-stage latency.
    drive(8'hA0, 8'h05, 1'b1);
    #1;
    check("comb_a5", 32'(out1), 32'hA5);
    drive(8'h00, 8'h00, 1'b0);
    check("single_not_yet", 32'(out_valid), 32'h0);
    @(negedge clk);
    check("single_data", 32'(out1_q), 32'hA5);
    check("single_valid", 32'(out_valid), 32'h1);
    check("single_any", 32'(any_q), 32'h1);
    @(negedge clk);
    check("single_valid_drop", 32'(out_valid), 32'h0);

    // Zero operands: valid result but no bits set.
    drive(8'h00, 8'h00, 1'b1);
    drive(8'h00, 8'h00, 1'b0);
    @(negedge clk);
    check("zero_data", 32'(out1_q), 32'h0);
    check("zero_any", 32'(any_q), 32'h0);
    check("zero_valid", 32'(out_valid), 32'h1);
    idle(2);

    // Back-to-back throughput: check first, then drive, at each falling edge.
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c >= PS && c < PS + 10) begin
        check($sformatf("tp_valid_%0d", c), 32'(out_valid), 32'h1);
        if (exp_q.size() > 0) check($sformatf("tp_data_%0d", c), 32'(out1_q), 32'(exp_q.pop_front()));
      end else begin
        check($sformatf("tp_idle_%0d", c), 32'(out_valid), 32'h0);
      end
      if (c < 10) begin
        in1 = tp_a[c]; in2 = tp_b[c]; in_valid = 1'b1;
        exp_q.push_back(tp_exp[c]);
      end else begin
        in1 = '0; in2 = '0; in_valid = 1'b0;
      end
    end
    check("tp_queue_empty", 32'(exp_q.size()), 32'h0);

    // Reset mid-stream, asserted between clock edges.
    drive(8'h03, 8'h0C, 1'b1);
    drive(8'h30, 8'hC0, 1'b1);
    drive(8'h55, 8'h2A, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_data", 32'(out1_q), 32'h0);
    check("mid_rst_any", 32'(any_q), 32'h0);
    check("mid_rst_out1", 32'(out1), 32'h7F);
    in1 = 8'h81; in2 = 8'h18;
    #1;
    check("mid_rst_out1_track", 32'(out1), 32'h99);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_stale_%0d", i), 32'(out_valid), 32'h0);
    end

`ifdef OR_GATE_STICKY_EN
    check("sticky_after_rst", 32'(sticky_q), 32'h0);
    drive(8'h01, 8'h00, 1'b1);
    drive(8'h00, 8'h10, 1'b1);
    drive(8'h80, 8'h00, 1'b1);
    idle(4);
    check("sticky_91", 32'(sticky_q), 32'h91);
    drive(8'h02, 8'h00, 1'b1);
    sticky_clr = 1'b1;
    @(negedge clk);
    check("sticky_cleared", 32'(sticky_q), 32'h0);
    sticky_clr = 1'b0;
    in_valid   = 1'b0;
    in1        = '0;
    @(negedge clk);
    @(negedge clk);
    check("sticky_02", 32'(sticky_q), 32'h02);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
